// File: rtl/seg_write_back_pipe.sv
// Write-back stage with a MEM/WB pipeline register. It selects the write-back source,
// extends sub-word loads, handles stall and flush, and counts retired instructions.
module seg_write_back_pipe #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 3,
    parameter int NB_CNT     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [LEN-1:0]        i_read_data,
    input  logic [LEN-1:0]        i_ALU_result,
    input  logic [LEN-1:0]        i_pc_plus4,
    input  logic [NB_ADDR-1:0]    i_write_register,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [2:0]            i_load_type,
    input  logic [1:0]            i_addr_lsb,
    output logic                  o_RegWrite,
    output logic [LEN-1:0]        o_write_data,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic                  o_valid,
    output logic [NB_CNT-1:0]     o_retired_count
);

    typedef enum logic [2:0] {
        LD_WORD   = 3'b000,
        LD_BYTE_S = 3'b001,
        LD_BYTE_U = 3'b010,
        LD_HALF_S = 3'b011,
        LD_HALF_U = 3'b100
    } load_type_e;

    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [LEN-1:0]     load_data;
    logic [LEN-1:0]     wb_data_d;

    logic               valid_q;
    logic               reg_write_q;
    logic [LEN-1:0]     data_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_CNT-1:0]  count_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_lane = i_read_data[7:0];
        case (i_addr_lsb)
            2'd1:    byte_lane = i_read_data[15:8];
            2'd2:    byte_lane = i_read_data[23:16];
            2'd3:    byte_lane = i_read_data[31:24];
            default: byte_lane = i_read_data[7:0];
        endcase
        half_lane = i_addr_lsb[1] ? i_read_data[31:16] : i_read_data[15:0];

        load_data = i_read_data;
        case (load_type_e'(i_load_type))
            LD_BYTE_S: load_data = {{(LEN-8){byte_lane[7]}}, byte_lane};
            LD_BYTE_U: load_data = {{(LEN-8){1'b0}}, byte_lane};
            LD_HALF_S: load_data = {{(LEN-16){half_lane[15]}}, half_lane};
            LD_HALF_U: load_data = {{(LEN-16){1'b0}}, half_lane};
            default:   load_data = i_read_data;
        endcase

        // MemtoReg 11 is unused by the decoder and falls back to the ALU result.
        wb_data_d = i_ALU_result;
        case (i_ctrl_wb_bus[1:0])
            SEL_MEM:  wb_data_d = load_data;
            SEL_LINK: wb_data_d = i_pc_plus4 + LEN'(4);
            default:  wb_data_d = i_ALU_result;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            count_q     <= '0;
        end else if (i_flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
        end else if (!i_stall) begin
            valid_q     <= i_valid;
            reg_write_q <= i_ctrl_wb_bus[NB_CTRL_WB-1];
            data_q      <= wb_data_d;
            addr_q      <= i_write_register;
            if (i_valid) begin
                count_q <= count_q + NB_CNT'(1);
            end
        end
    end

    // Register 0 is hard-wired to zero; its writes are dropped but the slot stays visible.
    assign o_RegWrite       = valid_q & reg_write_q & (addr_q != '0);
    assign o_write_data     = data_q;
    assign o_write_register = addr_q;
    assign o_valid          = valid_q;
    assign o_retired_count  = count_q;

endmodule

// File: tb/tb_seg_write_back_pipe.sv
// Directed bench for seg_write_back_pipe with a reference model and an expected-result queue;
// a second instance with a 4-bit counter exercises the counter wrap.
module tb_seg_write_back_pipe;

    logic        clk = 1'b0;
    logic        reset, valid, stall, flush;
    logic [31:0] read_data, alu_result, pc_plus4;
    logic [4:0]  write_reg;
    logic [2:0]  ctrl, load_type;
    logic [1:0]  addr_lsb;

    logic        o_rw, o_valid;
    logic [31:0] o_data, o_cnt;
    logic [4:0]  o_reg;
    logic        u4_rw, u4_valid;
    logic [31:0] u4_data;
    logic [4:0]  u4_reg;
    logic [3:0]  u4_cnt;

    typedef struct {
        logic        rw;
        logic        valid;
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        m_valid, m_rw;
    logic [31:0] m_data, m_cnt;
    logic [4:0]  m_addr;
    logic [3:0]  m_cnt4;

    always #5 clk = ~clk;

    seg_write_back_pipe dut (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_read_data(read_data), .i_ALU_result(alu_result), .i_pc_plus4(pc_plus4),
        .i_write_register(write_reg), .i_ctrl_wb_bus(ctrl), .i_load_type(load_type),
        .i_addr_lsb(addr_lsb), .o_RegWrite(o_rw), .o_write_data(o_data),
        .o_write_register(o_reg), .o_valid(o_valid), .o_retired_count(o_cnt)
    );

    seg_write_back_pipe #(.NB_CNT(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_read_data(read_data), .i_ALU_result(alu_result), .i_pc_plus4(pc_plus4),
        .i_write_register(write_reg), .i_ctrl_wb_bus(ctrl), .i_load_type(load_type),
        .i_addr_lsb(addr_lsb), .o_RegWrite(u4_rw), .o_write_data(u4_data),
        .o_write_register(u4_reg), .o_valid(u4_valid), .o_retired_count(u4_cnt)
    );

    function automatic logic [31:0] model_load(logic [31:0] rd, logic [2:0] lt, logic [1:0] lsb);
        logic [31:0] sb, sh;
        sb = rd >> (8 * lsb);
        sh = rd >> (16 * lsb[1]);
        case (lt)
            3'b001:  return {{24{sb[7]}}, sb[7:0]};
            3'b010:  return {24'h0, sb[7:0]};
            3'b011:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Update the model from the current inputs, queue the expectation, clock once, then compare.
    task automatic tick();
        exp_t e;
        if (reset) begin
            m_valid = 0; m_rw = 0; m_data = 0; m_addr = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_data = 0; m_addr = 0;
        end else if (!stall) begin
            m_valid = valid;
            m_rw    = ctrl[2];
            m_addr  = write_reg;
            case (ctrl[1:0])
                2'b01:   m_data = model_load(read_data, load_type, addr_lsb);
                2'b10:   m_data = pc_plus4 + 32'd4;
                default: m_data = alu_result;
            endcase
            if (valid) begin
                m_cnt++;
                m_cnt4 = m_cnt4 + 4'd1;
            end
        end
        e.rw = m_valid & m_rw & (m_addr != 0);
        e.valid = m_valid; e.data = m_data; e.addr = m_addr; e.cnt = m_cnt; e.cnt4 = m_cnt4;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("regwrite", 32'(o_rw), 32'(e.rw));
        check("valid", 32'(o_valid), 32'(e.valid));
        check("data", o_data, e.data);
        check("addr", 32'(o_reg), 32'(e.addr));
        check("count", o_cnt, e.cnt);
        check("count4", 32'(u4_cnt), 32'(e.cnt4));
    endtask

    task automatic set_op(logic v, logic [2:0] c, logic [31:0] alu, logic [4:0] r);
        valid = v; ctrl = c; alu_result = alu; write_reg = r;
    endtask

    initial begin
        reset = 1; valid = 0; stall = 0; flush = 0;
        read_data = 0; alu_result = 0; pc_plus4 = 0;
        write_reg = 0; ctrl = 0; load_type = 0; addr_lsb = 0;
        m_valid = 0; m_rw = 0; m_data = 0; m_addr = 0; m_cnt = 0; m_cnt4 = 0;

        // 1. reset, then release with no valid instruction
        tick(); tick();
        check("reset_data", o_data, 32'h0);
        reset = 0;
        tick();
        check("idle_count", o_cnt, 32'h0);

        // 2. sub-word loads
        set_op(1, 3'b101, 32'hDEAD_BEEF, 5'd5);
        read_data = 32'h1234_80FF; load_type = 3'b001; addr_lsb = 2'b01;
        tick();
        check("lb_signed", o_data, 32'hFFFF_FF80);
        load_type = 3'b100; addr_lsb = 2'b10;
        tick();
        check("lhu_upper", o_data, 32'h0000_1234);
        load_type = 3'b011; addr_lsb = 2'b11; read_data = 32'h9ABC_0001;
        tick();
        load_type = 3'b110;
        tick();
        load_type = 3'b010; addr_lsb = 2'b11;
        tick();

        // 3. link write, then write to register 0 suppressed
        set_op(1, 3'b110, 32'h0, 5'd31); pc_plus4 = 32'h0000_0040;
        tick();
        check("link_data", o_data, 32'h0000_0044);
        check("link_rw", 32'(o_rw), 32'd1);
        set_op(1, 3'b100, 32'h1C, 5'd0);
        tick();
        check("r0_rw", 32'(o_rw), 32'd0);
        set_op(1, 3'b111, 32'h77, 5'd9);
        tick();
        pc_plus4 = 32'hFFFF_FFFC; set_op(1, 3'b110, 32'h0, 5'd1);
        tick();
        check("link_wrap", o_data, 32'h0000_0000);

        // 4. stall holds everything, flush beats stall
        set_op(1, 3'b100, 32'hA5A5_0001, 5'd7);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_op(1, 3'b100, 32'h1000 + i, 5'(10 + i));
            tick();
        end
        check("stall_hold", o_data, 32'hA5A5_0001);
        flush = 1;
        tick();
        check("flush_valid", 32'(o_valid), 32'd0);
        stall = 0;
        tick();
        flush = 0;

        // 5. back-to-back stream after a fresh reset; 4-bit counter wraps at 16
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 10; i++) begin
            set_op(1, 3'b100, 32'(i * 3), 5'(i + 1));
            tick();
        end
        check("count10", o_cnt, 32'd10);
        for (int i = 0; i < 7; i++) begin
            set_op(1, 3'b000, 32'(i), 5'(i + 2));
            tick();
        end
        check("count4_wrap", 32'(u4_cnt), 32'd1);
        set_op(0, 3'b100, 32'h55, 5'd3);
        tick();

        // 6. reset pulse in the middle of a valid stream
        set_op(1, 3'b100, 32'h1111, 5'd4);
        tick(); tick();
        reset = 1; stall = 1;
        tick();
        check("midreset_cnt", o_cnt, 32'd0);
        reset = 0; stall = 0;
        set_op(1, 3'b100, 32'h2222, 5'd6);
        tick();
        check("resume_data", o_data, 32'h2222);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
